// File: rtl/pipo_arbiter_if.sv
// Handshake bundle between requesters, the shared PIPO register and its consumer.
// The design takes the slave view; the environment drives through master.
interface pipo_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] din;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      pout;
  logic                  pout_valid;
  logic                  pout_ready;
  logic [1:0]            owner;
  logic [7:0]            xfer_cnt;

  modport slave (
    input  req,
    input  din,
    input  pout_ready,
    output gnt,
    output pout,
    output pout_valid,
    output owner,
    output xfer_cnt
  );

  modport master (
    output req,
    output din,
    output pout_ready,
    input  gnt,
    input  pout,
    input  pout_valid,
    input  owner,
    input  xfer_cnt
  );
endinterface

// File: rtl/pipo_arbiter.sv
// Round-robin arbiter feeding one shared parallel-in/parallel-out register
// with a valid/ready consumer side and a handshake counter.
module pipo_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic           clk,
  input  logic           rst,
  pipo_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [1:0]       pick;
  logic [1:0]       idx;
  logic             hit;
  logic             free;
  logic             hs;
  logic             grant;
  logic [NREQ-1:0]  gnt;

  // First requesting index at or after ptr, wrapping mod 4.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr_q + 2'(k);
      if (!hit && bus.req[idx]) begin
        hit  = 1'b1;
        pick = idx;
      end
    end
  end

  assign free  = (state_q == IDLE) || bus.pout_ready;
  assign hs    = (state_q == HOLD) && bus.pout_ready;
  assign grant = free && hit && !rst;

  always_comb begin
    gnt = '0;
    if (grant) begin
      gnt[pick] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pout_d  = pout_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (hs) begin
      cnt_d = cnt_q + 8'd1;
    end
    if (grant) begin
      state_d = HOLD;
      pout_d  = bus.din[pick*WIDTH +: WIDTH];
      owner_d = pick;
      ptr_d   = pick + 2'd1;
    end else if (hs) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pout_q  <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pout_q  <= pout_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt        = gnt;
  assign bus.pout       = pout_q;
  assign bus.pout_valid = (state_q == HOLD);
  assign bus.owner      = owner_q;
  assign bus.xfer_cnt   = cnt_q;

  a_gnt_onehot: assert property (
    @(posedge clk) disable iff (rst) $onehot0(gnt)
  );

endmodule

// File: tb/tb_pipo_arbiter.sv
// Scoreboard bench: granted words are queued at grant time and
// matched against pout/owner when the consumer handshake happens.
module tb_pipo_arbiter;
  localparam int W = 4;
  localparam int N = 4;

  logic clk;
  logic rst;

  pipo_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

  pipo_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  logic       m_valid;
  logic [3:0] m_pout;
  logic [1:0] m_owner;
  int         m_ptr;
  logic [7:0] m_cnt;
  logic [3:0] m_gnt;
  logic [3:0] obs_gnt;
  logic [5:0] sbq[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic tick();
    logic       hitm;
    int         gi;
    int         j;
    logic [5:0] e;
    logic       hs;
    #2;
    m_gnt = '0;
    hitm  = 1'b0;
    gi    = 0;
    if (!m_valid || bus.pout_ready) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (!hitm && bus.req[j]) begin
          hitm     = 1'b1;
          gi       = j;
          m_gnt[j] = 1'b1;
        end
      end
    end
    obs_gnt = bus.gnt;
    check("gnt", bus.gnt, m_gnt);
    check("valid", bus.pout_valid, m_valid);
    check("cnt", bus.xfer_cnt, m_cnt);
    if (m_valid) begin
      check("pout", bus.pout, m_pout);
      check("owner", bus.owner, m_owner);
    end
    hs = m_valid && bus.pout_ready;
    if (hs) begin
      check("sb_nonempty", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("sb_word", {bus.owner, bus.pout}, e);
      end
      m_cnt = m_cnt + 8'd1;
    end
    if (hitm) begin
      m_valid = 1'b1;
      m_pout  = bus.din[gi*W +: W];
      m_owner = 2'(gi);
      m_ptr   = (gi + 1) % N;
      sbq.push_back({m_owner, m_pout});
    end else if (hs) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Asserts rst between edges and checks the asynchronous clear at once.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_gnt", bus.gnt, 0);
    check("rst_pout", bus.pout, 0);
    check("rst_valid", bus.pout_valid, 0);
    check("rst_owner", bus.owner, 0);
    check("rst_cnt", bus.xfer_cnt, 0);
    m_valid = 1'b0;
    m_pout  = '0;
    m_owner = '0;
    m_ptr   = 0;
    m_cnt   = '0;
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [3:0] rr_seq[5];

  initial begin
    n_vec = 0;
    n_err = 0;
    rst            = 1'b1;
    bus.req        = 4'b1111;
    bus.din        = '0;
    bus.pout_ready = 1'b0;
    m_valid = 1'b0;
    m_pout  = '0;
    m_owner = '0;
    m_ptr   = 0;
    m_cnt   = '0;
    @(posedge clk);
    #1;
    do_reset();
    bus.req = '0;

    // single load then hold under backpressure
    bus.req = 4'b0001;
    bus.din = 16'h0003;
    tick();
    check("load_gnt", obs_gnt, 4'b0001);
    bus.req = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("load_hold", bus.pout, 4'h3);
    end

    // round robin with everyone requesting
    do_reset();
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.req        = 4'b1111;
    bus.din        = 16'h9C5A;
    bus.pout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_seq", obs_gnt, rr_seq[i]);
    end
    check("rr_cnt", bus.xfer_cnt, 4);

    // backpressure with owner 2
    do_reset();
    bus.pout_ready = 1'b0;
    bus.req        = 4'b0100;
    bus.din        = 16'h0700;
    tick();
    bus.req = 4'b1011;
    bus.din = 16'hE07B;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_gnt", obs_gnt, 4'b0000);
    end
    check("bp_owner", bus.owner, 2);
    bus.pout_ready = 1'b1;
    tick();
    check("bp_next", obs_gnt, 4'b1000);
    bus.req = '0;
    tick();

    // drain: single word consumed, register empties
    do_reset();
    bus.pout_ready = 1'b0;
    bus.req        = 4'b0010;
    bus.din        = 16'h0060;
    tick();
    bus.req        = '0;
    bus.pout_ready = 1'b1;
    tick();
    check("drain_valid", bus.pout_valid, 0);
    check("drain_pout", bus.pout, 4'h6);
    check("drain_cnt", bus.xfer_cnt, 1);
    tick();

    // reset in the middle of a HOLD
    bus.pout_ready = 1'b0;
    bus.req        = 4'b1000;
    bus.din        = 16'hA000;
    tick();
    bus.req = '0;
    tick();
    check("pre_rst_pout", bus.pout, 4'hA);
    do_reset();
    bus.req = 4'b1100;
    bus.din = 16'h5900;
    tick();
    check("post_rst_gnt", obs_gnt, 4'b0100);
    bus.req = 4'b1000;
    bus.pout_ready = 1'b1;
    tick();
    bus.req = '0;
    tick();

    // counter wrap after 256 handshakes
    do_reset();
    bus.req        = 4'b1111;
    bus.pout_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      bus.din = 16'($urandom);
      tick();
    end
    check("wrap_cnt", bus.xfer_cnt, 0);

    // random traffic; requesters hold until granted
    do_reset();
    bus.req = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
          bus.req[i]         = 1'b1;
          bus.din[i*W +: W]  = 4'($urandom);
        end
      end
      bus.pout_ready = ($urandom_range(0, 2) != 0);
      tick();
      bus.req = bus.req & ~m_gnt;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipo_arbiter.md
PIPO_ARBITER -- requirements
Module: pipo_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: data width of the shared parallel-in/parallel-out register.
REQ-002 SHALL have parameter NREQ, default 4 (fixed at 4 in this revision): number of requesters.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port req  input  NREQ: bit i high = requester i has a word to load.
REQ-006 SHALL have port din  input  NREQ*WIDTH: requester i word at bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port gnt  output  NREQ: one-hot; bit i high = din slice i is captured at this clock edge.
REQ-008 SHALL have port pout  output  WIDTH: shared register contents.
REQ-009 SHALL have port pout_valid  output  1: pout holds an unconsumed word.
REQ-010 SHALL have port pout_ready  input  1: consumer accepts pout at an edge where pout_valid and pout_ready are both high.
REQ-011 SHALL have port owner  output  2: index of the requester whose word is in pout.
REQ-012 SHALL have port xfer_cnt  output  8: count of completed consumer handshakes.

Function
REQ-013 SHALL implement two states: IDLE (register empty) and HOLD (register full, pout_valid=1).
REQ-014 SHALL define "slot free" as state==IDLE, or state==HOLD with pout_ready=1.
REQ-015 SHALL assert gnt combinationally in any cycle where the slot is free and req!=0, with exactly one bit set.
REQ-016 SHALL select the granted index round-robin: first i with req[i]=1, searching ptr, ptr+1, ... mod 4.
REQ-017 SHALL, at the edge where gnt[i]=1, load pout<=din slice i, set owner<=i, set pout_valid<=1, and enter HOLD.
REQ-018 SHALL update ptr<=(i+1) mod 4 at every grant edge; ptr is unchanged otherwise.
REQ-019 SHALL keep pout and owner stable while in HOLD with pout_ready=0; gnt stays 0 in that case regardless of req.
REQ-020 SHALL, in HOLD with pout_ready=1 and req==0, clear pout_valid and return to IDLE; pout keeps its last value.
REQ-021 SHALL, in HOLD with pout_ready=1 and req!=0, grant and load the next word at the same edge (back-to-back; pout_valid stays 1).
REQ-022 SHALL increment xfer_cnt at each edge where pout_valid & pout_ready, wrapping 255->0.
REQ-023 SHALL ignore pout_ready when pout_valid=0: no count and no state change.
REQ-024 SHALL make load latency one edge: a word granted at edge N appears on pout with pout_valid=1 after edge N.
REQ-025 SHALL treat requesters as holding req and din stable until they observe gnt; the block does not buffer ungranted data.

Reset
REQ-026 SHALL, while rst=1 and independent of clk, force state=IDLE, pout=0, pout_valid=0, owner=0, ptr=0, xfer_cnt=0, and gnt=0.
REQ-027 SHALL discard any held word when rst asserts mid-HOLD; the first grant after rst deasserts follows REQ-016 with ptr=0.

Verification
REQ-028 SHALL pass single load: req=0001, din slice0=4'h3, pout_ready=0 -> gnt=0001 for one cycle; next cycle pout=3, owner=0, pout_valid=1; pout holds for 5 cycles.
REQ-029 SHALL pass round-robin: req=1111 held continuously, pout_ready=1 -> gnt sequence 0001,0010,0100,1000,0001; xfer_cnt advances by 1 per cycle.
REQ-030 SHALL pass backpressure: in HOLD with owner=2, pout_ready=0 for 4 cycles, req=1011 -> gnt=0000 throughout; on pout_ready=1 the grant goes to requester 3 (ptr=3).
REQ-031 SHALL pass drain: single word loaded, pout_ready=1, req=0 -> pout_valid falls after one edge; pout keeps its value; xfer_cnt=1.
REQ-032 SHALL pass reset mid-operation: rst pulse asserted between clock edges while pout=4'hA in HOLD -> pout=0, pout_valid=0, xfer_cnt=0 immediately; after release, req=1100 is granted to requester 2.
REQ-033 SHALL pass counter wrap: 256 handshakes -> xfer_cnt returns to 0.
